alu_logic_issuer: RTL
=====================

// Module: alu_logic_issuer
// PURPOSE
//   Initiator for the 16-bit combinational logic units (OR/NOR and siblings).
//   Accepts one command (opcode, a, b) per valid/ready handshake and drives registered operands to the units.
//   Waits SETTLE cycles, then captures the returned result plus zero/negative flags into a 2-entry response buffer.
//   Sits between the ALU control path and the logic-unit bank; the bank stays purely combinational.
// PARAMETERS
//   WIDTH   16  operand/result width
//   OP_W    3   opcode width
//   SETTLE  1   cycles operands are held before capture; legal range 1..15
// PORTS
//   clk         in   1      clock; all state changes on rising edge
//   rst_n       in   1      asynchronous reset, active-low
//   cmd_valid   in   1      command present
//   cmd_ready   out  1      issuer can accept a command
//   cmd_op      in   OP_W   opcode (alu_pkg encoding)
//   cmd_a       in   WIDTH  operand a
//   cmd_b       in   WIDTH  operand b
//   alu_a       out  WIDTH  registered operand a to logic units
//   alu_b       out  WIDTH  registered operand b to logic units
//   alu_op      out  OP_W   registered opcode to result mux
//   alu_result  in   WIDTH  selected result from logic-unit bank
//   rsp_valid   out  1      response buffer non-empty
//   rsp_ready   in   1      consumer takes head response
//   rsp_data    out  WIDTH  head result
//   rsp_zero    out  1      head result == 0
//   rsp_neg     out  1      head result[WIDTH-1]
//   busy        out  1      a command is in flight (state != IDLE)
// BEHAVIOUR
//   Reset (rst_n low, async): state=IDLE, settle counter=0, buffer emptied.
//     alu_a/alu_b/alu_op=0; rsp_valid/rsp_data/rsp_zero/rsp_neg=0; busy=0.
//     cmd_ready=0 while rst_n low.
//   Reset mid-operation aborts the in-flight command and flushes all buffered responses.
//   FSM states:
//     IDLE: cmd_ready = (count<2).
//       On cmd_valid&&cmd_ready, latch cmd_* into alu_*, load counter=SETTLE-1, go to DRIVE.
//     DRIVE: cmd_ready=0. Decrement counter; at 0 go to CAPTURE.
//     CAPTURE: cmd_ready=0. Push {alu_result, zero, neg} into buffer; return to IDLE.
//   Only one command is in flight at a time.
//     Acceptance requires count<2, so CAPTURE always has buffer space; no overflow is possible.
//   Latency: handshake at cycle N; alu_* valid from N+1.
//     Capture samples alu_result in cycle N+SETTLE+1.
//     rsp_valid rises in cycle N+SETTLE+2 if the buffer was empty.
//   Throughput: one command per SETTLE+2 cycles.
//   alu_a/alu_b/alu_op hold their last value after capture until the next accept; no toggling while idle.
//   Response buffer: 2-entry, first-word-fall-through, in order.
//     Pop on rsp_valid&&rsp_ready.
//     Push and pop in the same cycle: count unchanged, order preserved.
//     Pop on empty is ignored.
//   rsp_data/rsp_zero/rsp_neg read 0 when empty.
//     They are stable while rsp_valid=1 and rsp_ready=0.
//   Flags are computed at capture from the captured value, not at the head.
//   cmd_op is forwarded unchanged; the issuer never interprets opcode values.
// STRUCTURE
//   alu_pkg: WIDTH, OP_W, and opcode localparams
//     OP_OR=0, OP_NOR=1, OP_AND=2, OP_NAND=3, OP_XOR=4, OP_XNOR=5, OP_NOT=6, OP_PASS=7.
//   alu_pkg also holds the FSM state encodings IDLE=2'd0, DRIVE=2'd1, CAPTURE=2'd2.
//   Sub-module: resp_fifo2 (WIDTH+2 bits wide, 2 entries, FWFT, push/pop/count/async flush).
//   The FSM, counter and operand registers stay in alu_logic_issuer.
// TESTING (bench models alu_result = f(alu_op, alu_a, alu_b) combinationally)
//   1. Pulse rst_n low while in DRIVE
//      -> all outputs 0 immediately (async); buffer empty; cmd_ready=1 on first cycle after release.
//   2. OR: op=0, a=16'h00F0, b=16'h0F00, SETTLE=1, handshake at N
//      -> rsp_valid at N+3, rsp_data=16'h0FF0, zero=0, neg=0.
//   3. NOR: op=1, a=16'hFFFF, b=16'h0000
//      -> rsp_data=16'h0000, rsp_zero=1.
//   4. NOR: op=1, a=16'h0000, b=16'h0001
//      -> rsp_data=16'hFFFE, rsp_neg=1, rsp_zero=0.
//   5. Hold rsp_ready=0 and offer 3 commands back-to-back
//      -> 2 accepted; cmd_ready stays 0 at count=2; head stable.
//      Release rsp_ready -> responses drain in issue order; third command then accepted.
//   6. SETTLE=3; bench changes alu_result during DRIVE
//      -> captured value is the one present in the CAPTURE cycle (N+4).
//      Continuous rsp_ready=1 -> one response every 5 cycles, none lost.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcode encodings and FSM state encoding for the
// logic-unit issuer. Opcodes are listed for reference by the logic-unit bank
// and its consumers; the issuer forwards them without interpreting them.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_OR   = 3'd0;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/resp_fifo2.sv
// resp_fifo2: two-entry first-word-fall-through response buffer.
//   clk, rst_n  clock, async active-low reset (also flushes all entries)
//   push        write push_data (accepted when not full, or when popping)
//   push_data   entry to store
//   pop         consume head (ignored when empty)
//   head        oldest entry, reads 0 when empty
//   valid       buffer non-empty
//   count       number of stored entries (0..2)
module resp_fifo2 #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          valid,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  // When full, a simultaneous pop frees the slot the write pointer is on.
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;
  assign count = cnt;

endmodule

// File: rtl/alu_logic_issuer.sv
// alu_logic_issuer: accepts one (op, a, b) command per handshake, drives
// registered operands to the combinational logic-unit bank, waits SETTLE
// cycles and captures the bank result with zero/negative flags into a
// two-entry response buffer.
//   clk, rst_n                 clock, async active-low reset
//   cmd_valid/ready/op/a/b     command handshake
//   alu_a/alu_b/alu_op         registered operands to the logic-unit bank
//   alu_result                 result returned by the bank
//   rsp_valid/ready/data/zero/neg  response handshake (head of buffer)
//   busy                       a command is in flight
//
// state   | meaning
// IDLE    | waiting for a command; ready while the buffer has room
// DRIVE   | operands held on alu_*; settle counter running down
// CAPTURE | alu_result sampled and pushed into the response buffer
module alu_logic_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             busy
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  issuer_state_t    state;
  logic [3:0]       settle_cnt;
  logic [1:0]       fifo_count;
  logic             accept;
  logic             push;
  logic [WIDTH+1:0] push_data;
  logic [WIDTH+1:0] head;

  // Accepting only with a free slot guarantees CAPTURE never meets a full buffer.
  assign cmd_ready = rst_n && (state == IDLE) && (fifo_count < 2'd2);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_op     <= cmd_op;
            settle_cnt <= SETTLE_LOAD;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_cnt == 4'd0) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        CAPTURE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Flags are fixed at capture so the head entry never recomputes them.
  assign push      = (state == CAPTURE);
  assign push_data = {alu_result, (alu_result == '0), alu_result[WIDTH-1]};

  resp_fifo2 #(
    .DW (WIDTH + 2)
  ) u_resp_fifo2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (rsp_ready),
    .head      (head),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

  assign rsp_data = head[WIDTH+1:2];
  assign rsp_zero = head[1];
  assign rsp_neg  = head[0];

endmodule
